// File: rtl/mmio_router.sv
// mmio_router
// -----------
// Single-master MMIO router. A 32-bit byte-addressed master request is decoded
// against N_PORTS peripheral windows (2^WIN_W bytes each) and a small local
// register window. Peripheral accesses are forwarded with a valid/ready
// handshake and guarded by a ready timeout; unmatched accesses and timeouts
// return ERR_DATA and are recorded in the local error registers. At most one
// transaction is in flight.
//
// Ports
//   clk, rst_n                  : clock, synchronous active-low reset
//   m_valid, m_we, m_addr,
//   m_wdata, m_wstrb            : master request (held until m_ready)
//   m_ready, m_rdata            : one-cycle response pulse and read data
//   m_irq                       : registered interrupt to the master
//   s_valid[N_PORTS]            : per-port request valid (one-hot)
//   s_we, s_addr, s_wdata,
//   s_wstrb                     : request payload broadcast to every port
//   s_ready[N_PORTS], s_rdata   : per-port ready pulse and read data
//   s_irq[N_PORTS]              : per-port interrupt lines
//
// Local registers (offset from LOCAL_BASE)
//   0x0 IRQ_PEND   RO  s_irq
//   0x4 IRQ_EN     RW  bits[N_PORTS-1:0] port enables, bit31 error-irq enable
//   0x8 ERR_STATUS W1C bit0 decode error, bit1 timeout (sticky)
//   0xC ERR_ADDR   RO  address of the last faulting access

module mmio_router #(
    parameter int                    N_PORTS     = 2,
    parameter int                    SLV_ADDR_W  = 13,
    parameter int                    WIN_W       = 12,
    parameter logic [N_PORTS*32-1:0] PORT_BASE   = {32'h8000_1000, 32'h8000_0000},
    parameter logic [31:0]           LOCAL_BASE  = 32'h8000_F000,
    parameter int                    TIMEOUT_CYC = 255,
    parameter logic [31:0]           ERR_DATA    = 32'hDEAD_DEAD
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    m_valid,
    input  logic                    m_we,
    input  logic [31:0]             m_addr,
    input  logic [31:0]             m_wdata,
    input  logic [3:0]              m_wstrb,
    output logic                    m_ready,
    output logic [31:0]             m_rdata,
    output logic                    m_irq,

    output logic [N_PORTS-1:0]      s_valid,
    output logic                    s_we,
    output logic [SLV_ADDR_W-1:0]   s_addr,
    output logic [31:0]             s_wdata,
    output logic [3:0]              s_wstrb,
    input  logic [N_PORTS-1:0]      s_ready,
    input  logic [N_PORTS*32-1:0]   s_rdata,
    input  logic [N_PORTS-1:0]      s_irq
);

    localparam int PSEL_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);

    // Count value seen on the last permitted s_valid cycle.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    // Writable bits of IRQ_EN: one enable per port plus the error enable.
    localparam logic [31:0] IRQ_EN_MASK = 32'h8000_0000 | ((32'h1 << N_PORTS) - 32'h1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic [PSEL_W-1:0]   port_sel;
    logic [31:0]         addr_q;
    logic                we_q;
    logic [31:0]         wdata_q;
    logic [3:0]          wstrb_q;
    logic [CNT_W-1:0]    tmo_cnt;
    logic [31:0]         irq_en;
    logic [1:0]          err_status;
    logic [31:0]         err_addr;

    logic                port_hit;
    logic [PSEL_W-1:0]   port_idx;
    logic [N_PORTS-1:0]  port_onehot;
    logic                local_hit;
    logic [31:0]         local_rdata;
    logic [31:0]         irq_en_wr;

    assign s_we    = we_q;
    assign s_addr  = addr_q[SLV_ADDR_W-1:0];
    assign s_wdata = wdata_q;
    assign s_wstrb = wstrb_q;

    // Window decode. Scanning from the top index down lets the lowest
    // matching port overwrite any higher one, so overlapping windows resolve
    // to the lowest index.
    always_comb begin
        port_hit    = 1'b0;
        port_idx    = '0;
        port_onehot = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (m_addr[31:WIN_W] == PORT_BASE[i*32+WIN_W +: 32-WIN_W]) begin
                port_hit       = 1'b1;
                port_idx       = PSEL_W'(i);
                port_onehot    = '0;
                port_onehot[i] = 1'b1;
            end
        end
    end

    assign local_hit = (m_addr[31:4] == LOCAL_BASE[31:4]);

    always_comb begin
        local_rdata = '0;
        case (m_addr[3:2])
            2'd0:    local_rdata[N_PORTS-1:0] = s_irq;
            2'd1:    local_rdata = irq_en;
            2'd2:    local_rdata[1:0] = err_status;
            default: local_rdata = err_addr;
        endcase
    end

    // Byte-strobed merge of a write into IRQ_EN; unimplemented bits stay 0.
    always_comb begin
        irq_en_wr = irq_en;
        for (int b = 0; b < 4; b++) begin
            if (m_wstrb[b]) begin
                irq_en_wr[b*8 +: 8] = m_wdata[b*8 +: 8];
            end
        end
        irq_en_wr = irq_en_wr & IRQ_EN_MASK;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            port_sel   <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            tmo_cnt    <= '0;
            irq_en     <= '0;
            err_status <= '0;
            err_addr   <= '0;
            s_valid    <= '0;
            m_ready    <= 1'b0;
            m_rdata    <= '0;
            m_irq      <= 1'b0;
        end else begin
            m_irq <= (|(s_irq & irq_en[N_PORTS-1:0])) | (irq_en[31] & (|err_status));

            case (state)
                IDLE: begin
                    m_ready <= 1'b0;
                    if (m_valid) begin
                        addr_q  <= m_addr;
                        we_q    <= m_we;
                        wdata_q <= m_wdata;
                        wstrb_q <= m_wstrb;
                        if (port_hit) begin
                            port_sel <= port_idx;
                            s_valid  <= port_onehot;
                            tmo_cnt  <= '0;
                            state    <= FWD;
                        end else if (local_hit) begin
                            m_ready <= 1'b1;
                            state   <= RESP;
                            if (m_we) begin
                                case (m_addr[3:2])
                                    2'd1: irq_en <= irq_en_wr;
                                    2'd2: begin
                                        if (m_wstrb[0]) begin
                                            err_status <= err_status & ~m_wdata[1:0];
                                        end
                                    end
                                    default: ;
                                endcase
                            end else begin
                                m_rdata <= local_rdata;
                            end
                        end else begin
                            // Unmapped address: writes are dropped, reads get ERR_DATA.
                            m_ready       <= 1'b1;
                            m_rdata       <= ERR_DATA;
                            err_status[0] <= 1'b1;
                            err_addr      <= m_addr;
                            state         <= RESP;
                        end
                    end
                end

                FWD: begin
                    // A ready on the final permitted cycle still completes normally.
                    if (s_ready[port_sel]) begin
                        s_valid <= '0;
                        m_rdata <= s_rdata[port_sel*32 +: 32];
                        m_ready <= 1'b1;
                        state   <= RESP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        s_valid       <= '0;
                        m_rdata       <= ERR_DATA;
                        err_status[1] <= 1'b1;
                        err_addr      <= addr_q;
                        tmo_cnt       <= tmo_cnt + CNT_W'(1);
                        m_ready       <= 1'b1;
                        state         <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                RESP: begin
                    m_ready <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    s_valid <= '0;
                    m_ready <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_router.sv
// tb_mmio_router
// --------------
// Self-checking bench for mmio_router with default parameters. Directed
// scenarios cover reset, peripheral forwarding, timeout, decode errors,
// interrupts and reset during a forward; a randomized phase is checked against
// an address-range reference model of the router's register state.

module tb_mmio_router;

    localparam int NP = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;

    logic              m_valid = 1'b0;
    logic              m_we = 1'b0;
    logic [31:0]       m_addr = '0;
    logic [31:0]       m_wdata = '0;
    logic [3:0]        m_wstrb = '0;
    logic              m_ready;
    logic [31:0]       m_rdata;
    logic              m_irq;

    logic [NP-1:0]     s_valid;
    logic              s_we;
    logic [12:0]       s_addr;
    logic [31:0]       s_wdata;
    logic [3:0]        s_wstrb;
    logic [NP-1:0]     s_ready = '0;
    logic [NP*32-1:0]  s_rdata = '0;
    logic [NP-1:0]     s_irq = '0;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference model state
    logic [31:0] mdl_irq_en;
    logic [1:0]  mdl_err;
    logic [31:0] mdl_err_addr;

    always #5 clk = ~clk;

    mmio_router dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_valid (m_valid),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .m_irq   (m_irq),
        .s_valid (s_valid),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_ready (s_ready),
        .s_rdata (s_rdata),
        .s_irq   (s_irq)
    );

    // Target of an address: 0 = SPI, 1 = UART, 2 = local registers, 3 = unmapped.
    function automatic int target_of(input logic [31:0] addr);
        if (addr >= 32'h8000_0000 && addr < 32'h8000_1000) return 0;
        if (addr >= 32'h8000_1000 && addr < 32'h8000_2000) return 1;
        if (addr >= 32'h8000_F000 && addr < 32'h8000_F010) return 2;
        return 3;
    endfunction

    function automatic void model_reset();
        mdl_irq_en   = '0;
        mdl_err      = '0;
        mdl_err_addr = '0;
    endfunction

    // Applies one completed transaction to the model and returns the read data
    // the master should see (meaningless for writes).
    function automatic logic [31:0] model_txn(input logic we, input logic [31:0] addr,
                                              input logic [31:0] wdata, input logic [3:0] wstrb,
                                              input logic [31:0] slv_data, input logic [NP-1:0] irq,
                                              input bit tmo);
        logic [31:0] rd;
        int          reg_idx;
        rd = 32'h0;
        case (target_of(addr))
            0, 1: begin
                if (tmo) begin
                    rd           = 32'hDEAD_DEAD;
                    mdl_err      = mdl_err | 2'b10;
                    mdl_err_addr = addr;
                end else begin
                    rd = slv_data;
                end
            end
            2: begin
                reg_idx = int'((addr - 32'h8000_F000) / 4);
                if (we) begin
                    if (reg_idx == 1) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb[b]) mdl_irq_en[b*8 +: 8] = wdata[b*8 +: 8];
                        end
                        mdl_irq_en = mdl_irq_en & 32'h8000_0003;
                    end else if (reg_idx == 2 && wstrb[0]) begin
                        mdl_err = mdl_err & ~wdata[1:0];
                    end
                end else begin
                    case (reg_idx)
                        0:       rd = {30'h0, irq};
                        1:       rd = mdl_irq_en;
                        2:       rd = {30'h0, mdl_err};
                        default: rd = mdl_err_addr;
                    endcase
                end
            end
            default: begin
                rd           = 32'hDEAD_DEAD;
                mdl_err      = mdl_err | 2'b01;
                mdl_err_addr = addr;
            end
        endcase
        return rd;
    endfunction

    function automatic logic model_irq(input logic [NP-1:0] irq);
        return (|(irq & mdl_irq_en[NP-1:0])) | (mdl_irq_en[31] & (mdl_err != 2'b00));
    endfunction

    // Drives one master request and plays the selected peripheral, asserting
    // s_ready on the ready_after-th s_valid cycle (0 = never). lat counts the
    // request cycle as 1 and ends on the m_ready cycle.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int ready_after,
                           input logic [31:0] slv_data,
                           output logic [31:0] rdata, output int lat, output int sv_cnt,
                           output logic [NP-1:0] sv_seen, output logic [12:0] p_addr,
                           output logic p_we, output logic [31:0] p_wdata,
                           output logic [3:0] p_wstrb, output bit done);
        rdata   = '0;
        lat     = 1;
        sv_cnt  = 0;
        sv_seen = '0;
        p_addr  = '0;
        p_we    = 1'b0;
        p_wdata = '0;
        p_wstrb = '0;
        done    = 1'b0;
        @(negedge clk);
        m_valid = 1'b1;
        m_we    = we;
        m_addr  = addr;
        m_wdata = wdata;
        m_wstrb = wstrb;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            lat++;
            s_ready = '0;
            if (m_ready) begin
                done    = 1'b1;
                rdata   = m_rdata;
                m_valid = 1'b0;
            end else if (s_valid != '0) begin
                if (sv_cnt == 0) begin
                    p_addr  = s_addr;
                    p_we    = s_we;
                    p_wdata = s_wdata;
                    p_wstrb = s_wstrb;
                end
                sv_cnt++;
                sv_seen = sv_seen | s_valid;
                if (sv_cnt == ready_after) begin
                    s_ready = s_valid;
                    s_rdata = {NP{slv_data}};
                end
            end
        end
        m_valid = 1'b0;
        s_ready = '0;
    endtask

    // Local-window access that also keeps the model in step.
    task automatic local_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, output logic [31:0] obs,
                                output logic [31:0] exp, output bit done);
        int            lat, sv_cnt;
        logic [NP-1:0] sv_seen;
        logic [12:0]   p_addr;
        logic          p_we;
        logic [31:0]   p_wdata;
        logic [3:0]    p_wstrb;
        run_txn(we, addr, wdata, wstrb, 0, 32'h0, obs, lat, sv_cnt, sv_seen,
                p_addr, p_we, p_wdata, p_wstrb, done);
        exp = model_txn(we, addr, wdata, wstrb, 32'h0, s_irq, 1'b0);
    endtask

    task automatic test_reset();
        logic [31:0] obs, exp;
        bit          done;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        checks_total++;
        if ({m_ready, m_irq, s_valid} !== 4'b0 || m_rdata !== 32'h0) begin
            $display("[TB] FAIL reset_outputs: m_ready=%b m_irq=%b s_valid=%b m_rdata=%h, expected all 0",
                     m_ready, m_irq, s_valid, m_rdata);
        end else checks_passed++;
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            local_access(1'b0, 32'h8000_F000 + 32'(r * 4), 32'h0, 4'h0, obs, exp, done);
            checks_total++;
            if (!done || obs !== 32'h0) begin
                $display("[TB] FAIL reset_reg%0d: done=%0d read %h, expected 00000000", r, done, obs);
            end else checks_passed++;
        end
    endtask

    task automatic test_spi_read();
        logic [31:0]   rdata;
        int            lat, sv_cnt;
        logic [NP-1:0] sv_seen;
        logic [12:0]   p_addr;
        logic          p_we;
        logic [31:0]   p_wdata;
        logic [3:0]    p_wstrb;
        bit            done;
        logic [31:0]   exp;
        run_txn(1'b0, 32'h8000_0004, 32'h0, 4'h0, 2, 32'h0000_00A5, rdata, lat, sv_cnt,
                sv_seen, p_addr, p_we, p_wdata, p_wstrb, done);
        exp = model_txn(1'b0, 32'h8000_0004, 32'h0, 4'h0, 32'h0000_00A5, s_irq, 1'b0);
        checks_total++;
        if (!done || rdata !== 32'h0000_00A5 || rdata !== exp) begin
            $display("[TB] FAIL spi_read_data: done=%0d m_rdata=%h, expected 000000a5", done, rdata);
        end else checks_passed++;
        checks_total++;
        if (p_addr !== 13'h004 || p_we !== 1'b0) begin
            $display("[TB] FAIL spi_read_addr: s_addr=%h s_we=%b, expected 004 / 0", p_addr, p_we);
        end else checks_passed++;
        checks_total++;
        if (sv_seen !== 2'b01 || lat != 4) begin
            $display("[TB] FAIL spi_read_port: s_valid seen=%b latency=%0d, expected 01 / 4", sv_seen, lat);
        end else checks_passed++;
    endtask

    task automatic test_timeout();
        logic [31:0]   rdata, obs, exp;
        int            lat, sv_cnt;
        logic [NP-1:0] sv_seen;
        logic [12:0]   p_addr;
        logic          p_we;
        logic [31:0]   p_wdata;
        logic [3:0]    p_wstrb;
        bit            done, ldone;
        run_txn(1'b0, 32'h8000_1008, 32'h0, 4'h0, 0, 32'h0, rdata, lat, sv_cnt,
                sv_seen, p_addr, p_we, p_wdata, p_wstrb, done);
        exp = model_txn(1'b0, 32'h8000_1008, 32'h0, 4'h0, 32'h0, s_irq, 1'b1);
        checks_total++;
        if (!done || rdata !== 32'hDEAD_DEAD || rdata !== exp) begin
            $display("[TB] FAIL timeout_data: done=%0d m_rdata=%h, expected deaddead", done, rdata);
        end else checks_passed++;
        checks_total++;
        if (sv_cnt != 255 || sv_seen !== 2'b10) begin
            $display("[TB] FAIL timeout_len: s_valid cycles=%0d seen=%b, expected 255 / 10", sv_cnt, sv_seen);
        end else checks_passed++;
        local_access(1'b0, 32'h8000_F008, 32'h0, 4'h0, obs, exp, ldone);
        checks_total++;
        if (!ldone || obs !== 32'h2) begin
            $display("[TB] FAIL timeout_status: ERR_STATUS=%h, expected 00000002", obs);
        end else checks_passed++;
        local_access(1'b0, 32'h8000_F00C, 32'h0, 4'h0, obs, exp, ldone);
        checks_total++;
        if (!ldone || obs !== 32'h8000_1008) begin
            $display("[TB] FAIL timeout_addr: ERR_ADDR=%h, expected 80001008", obs);
        end else checks_passed++;
        local_access(1'b1, 32'h8000_F008, 32'h2, 4'hF, obs, exp, ldone);
        local_access(1'b0, 32'h8000_F008, 32'h0, 4'h0, obs, exp, ldone);
        checks_total++;
        if (!ldone || obs !== 32'h0) begin
            $display("[TB] FAIL timeout_clear: ERR_STATUS=%h, expected 00000000", obs);
        end else checks_passed++;
    endtask

    task automatic test_decode_error();
        logic [31:0]   rdata, obs, exp;
        int            lat, sv_cnt;
        logic [NP-1:0] sv_seen;
        logic [12:0]   p_addr;
        logic          p_we;
        logic [31:0]   p_wdata;
        logic [3:0]    p_wstrb;
        bit            done, ldone;
        run_txn(1'b1, 32'h1234_0000, 32'hCAFE_F00D, 4'hF, 1, 32'h0, rdata, lat, sv_cnt,
                sv_seen, p_addr, p_we, p_wdata, p_wstrb, done);
        exp = model_txn(1'b1, 32'h1234_0000, 32'hCAFE_F00D, 4'hF, 32'h0, s_irq, 1'b0);
        checks_total++;
        if (!done || lat != 2 || sv_seen !== 2'b00) begin
            $display("[TB] FAIL decode_resp: done=%0d latency=%0d s_valid seen=%b, expected 1 / 2 / 00",
                     done, lat, sv_seen);
        end else checks_passed++;
        local_access(1'b0, 32'h8000_F008, 32'h0, 4'h0, obs, exp, ldone);
        checks_total++;
        if (!ldone || obs !== 32'h1) begin
            $display("[TB] FAIL decode_status: ERR_STATUS=%h, expected 00000001", obs);
        end else checks_passed++;
        local_access(1'b0, 32'h8000_F00C, 32'h0, 4'h0, obs, exp, ldone);
        checks_total++;
        if (!ldone || obs !== 32'h1234_0000) begin
            $display("[TB] FAIL decode_addr: ERR_ADDR=%h, expected 12340000", obs);
        end else checks_passed++;
        local_access(1'b1, 32'h8000_F008, 32'h1, 4'hF, obs, exp, ldone);
        local_access(1'b0, 32'h8000_F008, 32'h0, 4'h0, obs, exp, ldone);
        checks_total++;
        if (!ldone || obs !== 32'h0) begin
            $display("[TB] FAIL decode_w1c: ERR_STATUS=%h, expected 00000000", obs);
        end else checks_passed++;
    endtask

    task automatic test_irq();
        logic [31:0] obs, exp;
        bit          ldone;
        local_access(1'b1, 32'h8000_F004, 32'hFFFF_FF02, 4'b1001, obs, exp, ldone);
        local_access(1'b0, 32'h8000_F004, 32'h0, 4'h0, obs, exp, ldone);
        checks_total++;
        if (!ldone || obs !== 32'h8000_0002) begin
            $display("[TB] FAIL irq_en_strobe: IRQ_EN=%h, expected 80000002", obs);
        end else checks_passed++;
        @(negedge clk);
        s_irq = 2'b10;
        @(negedge clk);
        checks_total++;
        if (m_irq !== 1'b1) begin
            $display("[TB] FAIL irq_uart: m_irq=%b, expected 1", m_irq);
        end else checks_passed++;
        s_irq = 2'b01;
        @(negedge clk);
        checks_total++;
        if (m_irq !== 1'b0) begin
            $display("[TB] FAIL irq_spi_masked: m_irq=%b, expected 0", m_irq);
        end else checks_passed++;
        local_access(1'b0, 32'h8000_F000, 32'h0, 4'h0, obs, exp, ldone);
        checks_total++;
        if (!ldone || obs !== 32'h1) begin
            $display("[TB] FAIL irq_pend: IRQ_PEND=%h, expected 00000001", obs);
        end else checks_passed++;
        s_irq = 2'b00;
    endtask

    task automatic test_random();
        logic [31:0]   addr, wdata, sd, rdata, exp;
        logic [3:0]    wstrb;
        logic          we;
        int            cls, ra, lat, sv_cnt;
        logic [NP-1:0] sv_seen, exp_seen;
        logic [12:0]   p_addr;
        logic          p_we;
        logic [31:0]   p_wdata;
        logic [3:0]    p_wstrb;
        bit            done;
        for (int k = 0; k < 40; k++) begin
            cls   = int'($urandom_range(0, 3));
            we    = 1'($urandom_range(0, 1));
            wdata = $urandom;
            wstrb = 4'($urandom_range(0, 15));
            sd    = $urandom;
            ra    = int'($urandom_range(1, 4));
            case (cls)
                0:       addr = 32'h8000_0000 + 32'($urandom_range(0, 4095));
                1:       addr = 32'h8000_1000 + 32'($urandom_range(0, 4095));
                2:       addr = 32'h8000_F000 + 32'(4 * $urandom_range(0, 3));
                default: addr = {4'h1, 28'($urandom)};
            endcase
            if (cls == 2 && addr[3:2] == 2'd2) wstrb = 4'hF;
            s_irq = NP'($urandom_range(0, 3));
            run_txn(we, addr, wdata, wstrb, ra, sd, rdata, lat, sv_cnt, sv_seen,
                    p_addr, p_we, p_wdata, p_wstrb, done);
            exp = model_txn(we, addr, wdata, wstrb, sd, s_irq, 1'b0);
            exp_seen = (cls == 0) ? 2'b01 : (cls == 1) ? 2'b10 : 2'b00;
            checks_total++;
            if (!done || sv_seen !== exp_seen || lat != ((cls < 2) ? ra + 2 : 2)) begin
                $display("[TB] FAIL rand%0d_route addr=%h: done=%0d s_valid seen=%b latency=%0d, expected seen=%b",
                         k, addr, done, sv_seen, lat, exp_seen);
            end else checks_passed++;
            if (!we) begin
                checks_total++;
                if (rdata !== exp) begin
                    $display("[TB] FAIL rand%0d_rdata addr=%h: m_rdata=%h, expected %h", k, addr, rdata, exp);
                end else checks_passed++;
            end
            if (cls < 2) begin
                checks_total++;
                if (p_addr !== addr[12:0] || p_we !== we || p_wdata !== wdata || p_wstrb !== wstrb) begin
                    $display("[TB] FAIL rand%0d_payload: s_addr=%h s_we=%b s_wdata=%h s_wstrb=%h, expected %h %b %h %h",
                             k, p_addr, p_we, p_wdata, p_wstrb, addr[12:0], we, wdata, wstrb);
                end else checks_passed++;
            end
            @(negedge clk);
            checks_total++;
            if (m_irq !== model_irq(s_irq)) begin
                $display("[TB] FAIL rand%0d_irq: m_irq=%b, expected %b", k, m_irq, model_irq(s_irq));
            end else checks_passed++;
        end
        s_irq = '0;
    endtask

    task automatic test_back_to_back();
        logic [31:0]   rdata, exp, sd;
        int            lat, sv_cnt;
        logic [NP-1:0] sv_seen;
        logic [12:0]   p_addr;
        logic          p_we;
        logic [31:0]   p_wdata;
        logic [3:0]    p_wstrb;
        bit            done;
        logic [31:0]   addrs [6] = '{32'h8000_F004, 32'h8000_F004, 32'h8000_0010,
                                     32'h8000_1ffc, 32'h8000_F008, 32'h8000_0020};
        logic          wes   [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            sd = $urandom;
            run_txn(wes[k], addrs[k], 32'h0000_0001, 4'hF, 1, sd, rdata, lat, sv_cnt,
                    sv_seen, p_addr, p_we, p_wdata, p_wstrb, done);
            exp = model_txn(wes[k], addrs[k], 32'h0000_0001, 4'hF, sd, s_irq, 1'b0);
            checks_total++;
            if (!done || (!wes[k] && rdata !== exp)) begin
                $display("[TB] FAIL b2b%0d addr=%h: done=%0d m_rdata=%h, expected %h", k, addrs[k], done, rdata, exp);
            end else checks_passed++;
        end
    endtask

    task automatic test_reset_mid_fwd();
        logic [31:0] obs, exp;
        bit          ldone;
        int          pulses;
        @(negedge clk);
        m_valid = 1'b1;
        m_we    = 1'b0;
        m_addr  = 32'h8000_0000;
        @(negedge clk);
        checks_total++;
        if (s_valid !== 2'b01) begin
            $display("[TB] FAIL midfwd_valid: s_valid=%b, expected 01", s_valid);
        end else checks_passed++;
        rst_n   = 1'b0;
        m_valid = 1'b0;
        @(negedge clk);
        checks_total++;
        if (s_valid !== 2'b00 || m_ready !== 1'b0) begin
            $display("[TB] FAIL midfwd_abort: s_valid=%b m_ready=%b, expected 00 / 0", s_valid, m_ready);
        end else checks_passed++;
        rst_n = 1'b1;
        model_reset();
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (m_ready || s_valid != '0) pulses++;
        end
        checks_total++;
        if (pulses != 0) begin
            $display("[TB] FAIL midfwd_quiet: %0d cycles with m_ready or s_valid, expected 0", pulses);
        end else checks_passed++;
        local_access(1'b0, 32'h8000_F00C, 32'h0, 4'h0, obs, exp, ldone);
        checks_total++;
        if (!ldone || obs !== 32'h0) begin
            $display("[TB] FAIL midfwd_erraddr: done=%0d ERR_ADDR=%h, expected 00000000", ldone, obs);
        end else checks_passed++;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_spi_read();
        test_timeout();
        test_decode_error();
        test_irq();
        test_random();
        test_back_to_back();
        test_reset_mid_fwd();
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/mmio_router.md
MMIO_ROUTER -- requirements
Module: mmio_router

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of downstream peripheral ports.
REQ-002 SHALL have parameter SLV_ADDR_W, default 13, byte-address width forwarded to each peripheral.
REQ-003 SHALL have parameter WIN_W, default 12, log2 of each port's window size in bytes (4 KiB).
REQ-004 SHALL have parameter PORT_BASE, default {32'h8000_1000, 32'h8000_0000}, packed N_PORTS x 32 base addresses; index 0 = SPI, index 1 = UART.
REQ-005 SHALL have parameter LOCAL_BASE, default 32'h8000_F000, base of the router's own 16-byte register window.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 255, 1..65535, cycles allowed for peripheral ready.
REQ-007 SHALL have parameter ERR_DATA, default 32'hDEAD_DEAD, read data returned on any error.
REQ-008 Ports: clk in 1 clock; rst_n in 1 synchronous active-low reset; one clock only.
REQ-009 Ports: m_valid in 1, m_we in 1, m_addr in 32 (byte), m_wdata in 32, m_wstrb in 4; m_ready out 1, m_rdata out 32, m_irq out 1.
REQ-010 Ports: s_valid out N_PORTS, s_we out 1, s_addr out SLV_ADDR_W, s_wdata out 32, s_wstrb out 4; s_ready in N_PORTS, s_rdata in N_PORTS*32, s_irq in N_PORTS.

Function
REQ-011 Handshake (both sides): requester holds valid and payload stable until ready; ready is a one-cycle pulse; requester drops valid the cycle after ready.
REQ-012 FSM states IDLE, FWD, RESP; reset state IDLE; one transaction outstanding at most.
REQ-013 In IDLE with m_valid=1, m_addr, m_we, m_wdata and m_wstrb are captured and decoded. Port i matches when m_addr[31:WIN_W]==PORT_BASE[i][31:WIN_W]. Lowest matching index wins. Local window matches when m_addr[31:4]==LOCAL_BASE[31:4].
REQ-014 On a port match: IDLE->FWD. s_valid[i]=1 from the next cycle, registered. s_addr=captured addr[SLV_ADDR_W-1:0]. s_we, s_wdata and s_wstrb are broadcast to all ports; only s_valid[i] is asserted.
REQ-015 In FWD, when s_ready[i]=1: s_valid drops the next cycle, s_rdata[i] is registered into m_rdata, and the FSM moves to RESP. The write rdata value is don't-care.
REQ-016 In FWD, the timeout counter counts cycles with s_valid high. When it equals TIMEOUT_CYC without s_ready: s_valid drops, m_rdata=ERR_DATA, ERR_STATUS[1] is set, ERR_ADDR is latched, and the FSM moves to RESP. A late s_ready after abort is ignored.
REQ-017 On no match (neither a port nor the local window): IDLE->RESP, m_rdata=ERR_DATA, ERR_STATUS[0] set, ERR_ADDR latched, writes discarded.
REQ-018 Local access: IDLE->RESP. A read loads m_rdata. A write updates registers at the RESP entry edge.
REQ-019 RESP: m_ready=1 for exactly one cycle, then IDLE. Minimum master latency is 2 cycles for local/error and 3 cycles for a zero-wait peripheral.
REQ-020 Local registers, offsets 0x0-0xC; unused bits read 0:
  - 0x0 IRQ_PEND RO = s_irq.
  - 0x4 IRQ_EN RW, bits[N_PORTS-1:0] plus bit31 = error-irq enable; honours m_wstrb per byte.
  - 0x8 ERR_STATUS, bit0 decode, bit1 timeout; sticky, write-1-to-clear.
  - 0xC ERR_ADDR RO, last faulting address.
REQ-021 m_irq is registered: |(s_irq & IRQ_EN[N_PORTS-1:0]) | (IRQ_EN[31] & |ERR_STATUS); one cycle latency from s_irq.
REQ-022 An error set and a W1C clear cannot coincide, because transactions are serialised; if both are applied, set wins.
REQ-023 Timeout counter width is clog2(TIMEOUT_CYC+1) and it does not wrap; it is cleared on FWD entry.

Reset
REQ-024 When rst_n=0 at a clock edge:
  - FSM returns to IDLE.
  - Outputs: s_valid=0, m_ready=0, m_rdata=0, m_irq=0.
  - Registers: IRQ_EN=0, ERR_STATUS=0, ERR_ADDR=0, timeout counter=0.
REQ-025 Reset mid-FWD aborts the transaction without an m_ready pulse; s_valid is 0 on the first cycle after the reset edge.

Verification
REQ-026 Read 0x8000_0004, SPI s_ready on 2nd s_valid cycle with s_rdata=0x0000_00A5 -> s_addr=0x004, m_ready pulse with m_rdata=0x0000_00A5, s_valid[1] never high.
REQ-027 Read 0x8000_1008, UART never ready, TIMEOUT_CYC=255 -> s_valid[1] high exactly 255 cycles, m_rdata=0xDEAD_DEAD, ERR_STATUS=0x2, ERR_ADDR=0x8000_1008.
REQ-028 Write 0x1234_0000 -> m_ready within 2 cycles, no s_valid, ERR_STATUS=0x1; then write 0x1 to 0x8000_F008 -> ERR_STATUS reads 0.
REQ-029 Write IRQ_EN=0x8000_0002 with m_wstrb=4'b1001 -> IRQ_EN=0x8000_0002. Then assert s_irq=2'b10 -> m_irq=1 one cycle later. With s_irq=2'b01 -> m_irq=0.
REQ-030 rst_n=0 during FWD, s_valid[0]=1 -> next cycle s_valid=0, m_ready=0, FSM IDLE; a new read to 0x8000_F00C completes with m_rdata=0.
